jtag_shift_engine: RTL and testbench

JTAG_SHIFT_ENGINE -- requirements
Module: jtag_shift_engine

---
 rtl/jtag_shift_engine.sv | 136 +++++++++++++
 tb/tb_jtag_shift_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_engine.sv
// jtag_shift_engine: command-driven JTAG TAP driver shifting tx words out on TDI/TMS and capturing TDO into rx words
module jtag_shift_engine #(
  parameter int DATA_W = 32,
  parameter int LEN_W = 16,
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_nbits,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              busy
);
  localparam int WW = $clog2(DATA_W);
  typedef enum logic [2:0] {IDLE, LOAD, TCK_LO, TCK_HI, PUSH, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [LEN_W-1:0] total, cnt, cnt_n, lo_idx;
  logic [DIV_W-1:0] div, dcnt;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [DATA_W-1:0] sh;
  logic scan, last, bound, lo_bit, nxt_tms, nxt_tdi;
  assign busy = state != IDLE;
  // Next-bit bookkeeping and the tms/tdi values presented when a TCK_LO phase is entered
  always_comb begin
    scan = op[1];
    cnt_n = cnt + 1'b1;
    wcnt_n = wcnt + 1'b1;
    last = cnt_n == total;
    bound = wcnt == WW'(DATA_W - 1);
    lo_bit = (state == LOAD) ? tx_data[0] : sh[wcnt_n];
    lo_idx = (state == LOAD) ? cnt : cnt_n;
    nxt_tms = (op == 2'd0) ? (lo_idx < LEN_W'(5)) :
              (op == 2'd1) ? lo_bit :
              (op == 2'd3) && (lo_idx == total - LEN_W'(1));
    nxt_tdi = scan & lo_bit;
  end
  // Main FSM: TCK phase timing, tx/rx handshakes and registered pin outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      {tck, tms, tdi, tx_ready, rx_valid, cmd_ready} <= '0;
      rx_data <= '0;
      sh <= '0;
      op <= '0;
      total <= '0;
      cnt <= '0;
      div <= '0;
      dcnt <= '0;
      wcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= !(cmd_valid && cmd_ready);
          if (cmd_valid && cmd_ready) begin
            op <= cmd_op;
            total <= (cmd_op == 2'd0) ? LEN_W'(6) : cmd_nbits;
            div <= clk_div;
            cnt <= '0;
            wcnt <= '0;
            rx_data <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (cnt == total) begin
            state <= DONE;
          end else if (op == 2'd0 || (tx_ready && tx_valid)) begin
            if (op != 2'd0) sh <= tx_data;
            tx_ready <= 1'b0;
            tms <= nxt_tms;
            tdi <= nxt_tdi;
            dcnt <= '0;
            state <= TCK_LO;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        TCK_LO: begin
          dcnt <= (dcnt == div) ? '0 : dcnt + 1'b1;
          if (dcnt == div) begin
            tck <= 1'b1;
            rx_data[wcnt] <= tdo;
            state <= TCK_HI;
          end
        end
        TCK_HI: begin
          dcnt <= (dcnt == div) ? '0 : dcnt + 1'b1;
          if (dcnt == div) begin
            tck <= 1'b0;
            cnt <= cnt_n;
            wcnt <= bound ? '0 : wcnt_n;
            tms <= 1'b0;
            tdi <= 1'b0;
            if (scan && (last || bound)) begin
              rx_valid <= 1'b1;
              state <= PUSH;
            end else if (last) begin
              state <= DONE;
            end else if (bound) begin
              state <= LOAD;
            end else begin
              tms <= nxt_tms;
              tdi <= nxt_tdi;
              state <= TCK_LO;
            end
          end
        end
        PUSH: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            rx_data <= '0;
            state <= (cnt == total) ? DONE : LOAD;
          end
        end
        default: begin
          {tck, tms, tdi} <= '0;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb_jtag_shift_engine: table-driven checks of the JTAG shift engine with tx/rx scoreboards and pin monitor
module tb_jtag_shift_engine;
  logic clk = 0, rst_n = 0;
  logic [7:0] clk_div = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [15:0] cmd_nbits = 0;
  logic tx_valid = 0, tx_ready;
  logic [31:0] tx_data = 0;
  logic rx_valid, rx_ready = 1;
  logic [31:0] rx_data;
  logic tck, tms, tdi, tdo, busy;
  int tests = 0, fails = 0;
  int pulses, hi_bad, min_lo, max_lo, stall_bad, tx_hs, rx_hs, hl, ll, cur_div, tx_wait, rx_stall, busy_cyc;
  logic ptck = 0;
  logic [63:0] tms_bits, tdi_bits;
  logic [31:0] txq[$], rxq[$];
  int tdq[$];

  jtag_shift_engine #(.DATA_W(32), .LEN_W(16), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_nbits(cmd_nbits), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .busy(busy));

  assign tdo = tdi;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op; int nb; int dv; logic [31:0] w0, w1; int txd, rxs;
    int npulse; logic [63:0] tms_e, tdi_e; int ntx, nrx; logic [31:0] r0, r1;
  } vec_t;
  vec_t v[7];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic clear_mon();
    pulses = 0; hi_bad = 0; min_lo = 1000000; max_lo = 0; stall_bad = 0;
    tx_hs = 0; rx_hs = 0; tms_bits = 0; tdi_bits = 0; tx_wait = 0;
  endtask

  // Pin monitor: records tms/tdi at each tck rise and measures phase lengths in clk cycles
  initial forever begin
    @(negedge clk);
    if (tck && !ptck) begin
      if (pulses > 0) begin
        if (ll < min_lo) min_lo = ll;
        if (ll > max_lo) max_lo = ll;
      end
      if (pulses < 64) begin
        tms_bits[pulses] = tms;
        tdi_bits[pulses] = tdi;
      end
      pulses++;
      hl = 1;
    end else if (tck) hl++;
    if (!tck && ptck) begin
      if (hl != cur_div + 1) hi_bad++;
      ll = 1;
    end else if (!tck) ll++;
    ptck = tck;
  end

  // tx source: offers queued words, withholding each for its programmed delay
  initial forever begin
    @(negedge clk);
    if (tx_ready && txq.size() > 0) begin
      if (tx_wait < tdq[0]) begin
        tx_valid = 0;
        tx_wait++;
      end else begin
        tx_valid = 1;
        tx_data = txq[0];
      end
    end else tx_valid = 0;
    if (tx_ready && !tx_valid && tck) stall_bad++;
    if (tx_valid && tx_ready) begin
      void'(txq.pop_front());
      void'(tdq.pop_front());
      tx_wait = 0;
      tx_hs++;
    end
  end

  // rx sink: optional back-pressure, then pops the expected-word scoreboard on each handshake
  initial forever begin
    @(negedge clk);
    if (rx_valid && rx_stall > 0) begin
      rx_ready = 0;
      rx_stall--;
    end else rx_ready = 1;
    if (rx_valid && !rx_ready && tck) stall_bad++;
    if (rx_valid && rx_ready) begin
      rx_hs++;
      if (rxq.size() == 0) chk("rx_unexpected", {32'h0, rx_data}, 64'hffffffff);
      else chk("rx_word", {32'h0, rx_data}, {32'h0, rxq.pop_front()});
    end
  end

  task automatic run_cmd(input logic [1:0] op, input int nb, input int dv);
    int t;
    cur_div = dv;
    @(negedge clk);
    cmd_op = op; cmd_nbits = 16'(nb); clk_div = 8'(dv); cmd_valid = 1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    cmd_valid = 0;
    clk_div = ~8'(dv);
    busy_cyc = 0;
    t = 0;
    while (t < 20000) begin
      @(negedge clk);
      if (!busy) break;
      busy_cyc++;
      t++;
    end
    if (t >= 20000) chk("cmd_timeout", 1, 0);
  endtask

  initial begin
    int t;
    rx_stall = 0; cur_div = 0;
    clear_mon();
    v[0] = '{2'd0, 99, 0, 32'h0, 32'h0, 0, 0, 6, 64'h1f, 64'h0, 0, 0, 32'h0, 32'h0};
    v[1] = '{2'd2, 8, 3, 32'ha5, 32'h0, 0, 0, 8, 64'h0, 64'ha5, 1, 1, 32'ha5, 32'h0};
    v[2] = '{2'd3, 40, 1, 32'hdeadbeef, 32'h12, 0, 0, 40, 64'h80_0000_0000, 64'h12_deadbeef, 2, 2, 32'hdeadbeef, 32'h12};
    v[3] = '{2'd2, 40, 0, 32'hdeadbeef, 32'h12, 20, 10, 40, 64'h0, 64'h12_deadbeef, 2, 2, 32'hdeadbeef, 32'h12};
    v[4] = '{2'd1, 7, 2, 32'hffffff5b, 32'h0, 0, 0, 7, 64'h5b, 64'h0, 1, 0, 32'h0, 32'h0};
    v[5] = '{2'd2, 12, 0, 32'hfffffabc, 32'h0, 0, 0, 12, 64'h0, 64'habc, 1, 1, 32'habc, 32'h0};
    v[6] = '{2'd2, 0, 0, 32'h1111, 32'h0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 32'h0, 32'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", {tck, tms, tdi, tx_ready, rx_valid, busy, cmd_ready}, 0);
    chk("reset_rx_data", {32'h0, rx_data}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", cmd_ready, 1);
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      txq = {v[i].w0, v[i].w1};
      tdq = {0, v[i].txd};
      rxq.delete();
      if (v[i].nrx > 0) rxq.push_back(v[i].r0);
      if (v[i].nrx > 1) rxq.push_back(v[i].r1);
      rx_stall = v[i].rxs;
      run_cmd(v[i].op, v[i].nb, v[i].dv);
      repeat (3) @(negedge clk);
      $display("vector %0d op=%0d nbits=%0d", i, v[i].op, v[i].nb);
      chk("pulses", pulses, v[i].npulse);
      chk("tms_bits", tms_bits, v[i].tms_e);
      chk("tdi_bits", tdi_bits, v[i].tdi_e);
      chk("tx_handshakes", tx_hs, v[i].ntx);
      chk("rx_handshakes", rx_hs, v[i].nrx);
      chk("rx_left", rxq.size(), 0);
      chk("tck_high_len", hi_bad, 0);
      chk("tck_moved_in_stall", stall_bad, 0);
      if (v[i].npulse > 1) chk("tck_low_min", min_lo, v[i].dv + 1);
      if (v[i].npulse > 1 && v[i].npulse <= 32) chk("tck_low_max", max_lo, v[i].dv + 1);
      if (v[i].npulse == 0) chk("busy_cycles_zero_len", busy_cyc, 2);
    end
    // Zero-length TMS sequence: two busy cycles, no pulse, no handshakes
    clear_mon();
    txq = {32'h77}; tdq = {0}; rxq.delete();
    run_cmd(2'd1, 0, 0);
    repeat (3) @(negedge clk);
    chk("tms0_busy", busy_cyc, 2);
    chk("tms0_pulses", pulses, 0);
    chk("tms0_tx", tx_hs, 0);
    chk("tms0_rx", rx_hs, 0);
    // Reset in the middle of a 32-bit scan
    clear_mon();
    txq = {32'hcafef00d}; tdq = {0}; rxq.delete();
    cur_div = 1;
    @(negedge clk);
    cmd_op = 2'd2; cmd_nbits = 16'd32; clk_div = 8'd1; cmd_valid = 1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    cmd_valid = 0;
    t = 0;
    while (pulses < 13 && t < 2000) begin @(negedge clk); t++; end
    chk("mid_reset_reach_bit13", t < 2000, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_reset_pins", {tck, tms, tdi, tx_ready, rx_valid, busy, cmd_ready}, 0);
    chk("mid_reset_rx_data", {32'h0, rx_data}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("mid_reset_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("mid_reset_no_rx", rx_hs, 0);
    chk("mid_reset_no_more_tck", pulses, 13);
    txq.delete(); tdq.delete();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
